// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the instruction-side and
// data-side miss ports. It grants one requester at a time (round robin on
// conflicts), forwards the latched vpn to the walker, waits for the walk result
// and returns it to the requester that owns the walk.
//
// Optional feature: define PTW_ARB_TIMEOUT_EN to abandon a walk that gets no
// walker response within TIMEOUT_CYCLES WAIT cycles. The owner then sees a
// response with error=1 and ppn=0. Without the macro, WAIT lasts until the
// walker responds.
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both 1. io_*_req_ready is combinational from the valids and is only ever
// given in IDLE. io_ptw_req_valid/vpn are held stable until io_ptw_req_ready.
// io_ptw_resp_valid and io_*_resp_valid are one-cycle pulses with no
// back-pressure. The resp bits always show the last latched result.
module ptw_arbiter #(
  parameter int VPN_W          = 32,
  parameter int PPN_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_imem_req_valid,
  output logic             io_imem_req_ready,
  input  logic [VPN_W-1:0] io_imem_req_bits_vpn,
  input  logic             io_dmem_req_valid,
  output logic             io_dmem_req_ready,
  input  logic [VPN_W-1:0] io_dmem_req_bits_vpn,
  output logic             io_imem_resp_valid,
  output logic             io_imem_resp_bits_error,
  output logic [PPN_W-1:0] io_imem_resp_bits_ppn,
  output logic             io_dmem_resp_valid,
  output logic             io_dmem_resp_bits_error,
  output logic [PPN_W-1:0] io_dmem_resp_bits_ppn,
  output logic             io_ptw_req_valid,
  input  logic             io_ptw_req_ready,
  output logic [VPN_W-1:0] io_ptw_req_bits_vpn,
  input  logic             io_ptw_resp_valid,
  input  logic             io_ptw_resp_bits_error,
  input  logic [PPN_W-1:0] io_ptw_resp_bits_ppn,
  output logic             io_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Requester identity; also used for the round-robin preference.
  localparam logic OWN_IMEM = 1'b0;
  localparam logic OWN_DMEM = 1'b1;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;   // requester that owns the current walk
  logic             prio_q, prio_d;     // requester that wins the next conflict
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [PPN_W-1:0] ppn_q, ppn_d;
  logic             err_q, err_d;
  logic             ptw_req_valid_q, ptw_req_valid_d;
  logic             imem_resp_valid_q, imem_resp_valid_d;
  logic             dmem_resp_valid_q, dmem_resp_valid_d;
  logic             busy_q, busy_d;

  logic             imem_grant;
  logic             dmem_grant;

`ifdef PTW_ARB_TIMEOUT_EN
  // The counter holds the number of WAIT cycles already spent; the walk is
  // abandoned in the WAIT cycle that would bring it to TIMEOUT_CYCLES.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`else
  // Keeps the parameter referenced in the build that has no timeout.
  logic unused_tmo;
  assign unused_tmo = ^8'(TIMEOUT_CYCLES);
`endif

  // Pick at most one requester while idle; the preferred side wins a conflict.
  always_comb begin
    imem_grant = 1'b0;
    dmem_grant = 1'b0;
    if (state_q == ST_IDLE) begin
      if (io_imem_req_valid && io_dmem_req_valid) begin
        if (prio_q == OWN_IMEM) imem_grant = 1'b1;
        else                    dmem_grant = 1'b1;
      end else if (io_imem_req_valid) begin
        imem_grant = 1'b1;
      end else if (io_dmem_req_valid) begin
        dmem_grant = 1'b1;
      end
    end
  end

  // Ready is withheld while reset is asserted so nothing can transfer.
  assign io_imem_req_ready = imem_grant & ~reset;
  assign io_dmem_req_ready = dmem_grant & ~reset;

  assign io_ptw_req_valid        = ptw_req_valid_q;
  assign io_ptw_req_bits_vpn     = vpn_q;
  assign io_imem_resp_valid      = imem_resp_valid_q;
  assign io_dmem_resp_valid      = dmem_resp_valid_q;
  assign io_imem_resp_bits_error = err_q;
  assign io_dmem_resp_bits_error = err_q;
  assign io_imem_resp_bits_ppn   = ppn_q;
  assign io_dmem_resp_bits_ppn   = ppn_q;
  assign io_busy                 = busy_q;

  // Next state and next registered outputs for one walk: grant, issue, wait, return.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    prio_d            = prio_q;
    vpn_d             = vpn_q;
    ppn_d             = ppn_q;
    err_d             = err_q;
    ptw_req_valid_d   = ptw_req_valid_q;
    imem_resp_valid_d = 1'b0;
    dmem_resp_valid_d = 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
    tmo_cnt_d         = tmo_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (imem_grant) begin
          owner_d         = OWN_IMEM;
          vpn_d           = io_imem_req_bits_vpn;
          ptw_req_valid_d = 1'b1;
          state_d         = ST_REQ;
        end else if (dmem_grant) begin
          owner_d         = OWN_DMEM;
          vpn_d           = io_dmem_req_bits_vpn;
          ptw_req_valid_d = 1'b1;
          state_d         = ST_REQ;
        end
      end
      ST_REQ: begin
        if (io_ptw_req_ready) begin
          ptw_req_valid_d = 1'b0;
          state_d         = ST_WAIT;
`ifdef PTW_ARB_TIMEOUT_EN
          tmo_cnt_d       = 8'd0;
`endif
        end
      end
      ST_WAIT: begin
        // A real response always beats a timeout landing in the same cycle.
        if (io_ptw_resp_valid) begin
          err_d             = io_ptw_resp_bits_error;
          ppn_d             = io_ptw_resp_bits_ppn;
          imem_resp_valid_d = (owner_q == OWN_IMEM);
          dmem_resp_valid_d = (owner_q == OWN_DMEM);
          state_d           = ST_RESP;
        end
`ifdef PTW_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          err_d             = 1'b1;
          ppn_d             = '0;
          imem_resp_valid_d = (owner_q == OWN_IMEM);
          dmem_resp_valid_d = (owner_q == OWN_DMEM);
          state_d           = ST_RESP;
        end else begin
          tmo_cnt_d         = tmo_cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: begin
        // The side just served yields the next conflict to the other side.
        prio_d  = ~owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State register and registered outputs; reset abandons any walk in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      owner_q           <= OWN_IMEM;
      prio_q            <= OWN_IMEM;
      vpn_q             <= '0;
      ppn_q             <= '0;
      err_q             <= 1'b0;
      ptw_req_valid_q   <= 1'b0;
      imem_resp_valid_q <= 1'b0;
      dmem_resp_valid_q <= 1'b0;
      busy_q            <= 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
      tmo_cnt_q         <= 8'd0;
`endif
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      prio_q            <= prio_d;
      vpn_q             <= vpn_d;
      ppn_q             <= ppn_d;
      err_q             <= err_d;
      ptw_req_valid_q   <= ptw_req_valid_d;
      imem_resp_valid_q <= imem_resp_valid_d;
      dmem_resp_valid_q <= dmem_resp_valid_d;
      busy_q            <= busy_d;
`ifdef PTW_ARB_TIMEOUT_EN
      tmo_cnt_q         <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: directed walks plus randomized traffic on both requesters
// and a randomly behaving walker, checked cycle by cycle against a
// transaction-level reference model. Build with PTW_ARB_TIMEOUT_EN defined to
// cover the walk timeout (the bench sets TIMEOUT_CYCLES to 4).
`timescale 1ns/1ps
module tb_ptw_arbiter;
  localparam int VPN_W = 32;
  localparam int PPN_W = 32;
  localparam int TMO   = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             io_imem_req_valid, io_imem_req_ready;
  logic [VPN_W-1:0] io_imem_req_bits_vpn;
  logic             io_dmem_req_valid, io_dmem_req_ready;
  logic [VPN_W-1:0] io_dmem_req_bits_vpn;
  logic             io_imem_resp_valid, io_imem_resp_bits_error;
  logic [PPN_W-1:0] io_imem_resp_bits_ppn;
  logic             io_dmem_resp_valid, io_dmem_resp_bits_error;
  logic [PPN_W-1:0] io_dmem_resp_bits_ppn;
  logic             io_ptw_req_valid, io_ptw_req_ready;
  logic [VPN_W-1:0] io_ptw_req_bits_vpn;
  logic             io_ptw_resp_valid, io_ptw_resp_bits_error;
  logic [PPN_W-1:0] io_ptw_resp_bits_ppn;
  logic             io_busy;

  ptw_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_bits_vpn(io_imem_req_bits_vpn),
    .io_dmem_req_valid(io_dmem_req_valid), .io_dmem_req_ready(io_dmem_req_ready),
    .io_dmem_req_bits_vpn(io_dmem_req_bits_vpn),
    .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_bits_error(io_imem_resp_bits_error),
    .io_imem_resp_bits_ppn(io_imem_resp_bits_ppn),
    .io_dmem_resp_valid(io_dmem_resp_valid), .io_dmem_resp_bits_error(io_dmem_resp_bits_error),
    .io_dmem_resp_bits_ppn(io_dmem_resp_bits_ppn),
    .io_ptw_req_valid(io_ptw_req_valid), .io_ptw_req_ready(io_ptw_req_ready),
    .io_ptw_req_bits_vpn(io_ptw_req_bits_vpn),
    .io_ptw_resp_valid(io_ptw_resp_valid), .io_ptw_resp_bits_error(io_ptw_resp_bits_error),
    .io_ptw_resp_bits_ppn(io_ptw_resp_bits_ppn),
    .io_busy(io_busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One walk at a time: granted -> issued to walker -> result -> one return cycle.
  logic             m_active;    // a walk exists (grant seen, return cycle not yet over)
  logic             m_sent;      // walker has taken the request
  logic             m_resp_now;  // this cycle is the return cycle
  logic             m_owner;     // 0 imem, 1 dmem
  logic             m_rr;        // side that wins the next conflict
  logic [VPN_W-1:0] m_vpn;
  logic [PPN_W-1:0] m_ppn;
  logic             m_err;
  int               m_wait;      // WAIT cycles without a response
  logic [VPN_W-1:0] exp_q[$];    // vpns granted but not yet taken by the walker
  int               grant_log[$];
  int               n_accepts;

  task automatic model_reset();
    m_active = 1'b0; m_sent = 1'b0; m_resp_now = 1'b0; m_owner = 1'b0;
    m_rr = 1'b0; m_vpn = '0; m_ppn = '0; m_err = 1'b0; m_wait = 0;
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  logic             d_imem_valid, d_dmem_valid, d_ptw_req_ready, d_ptw_resp_valid, d_ptw_resp_err;
  logic [VPN_W-1:0] d_imem_vpn, d_dmem_vpn;
  logic [PPN_W-1:0] d_ptw_resp_ppn;

  task automatic clear_drv();
    d_imem_valid = 1'b0; d_dmem_valid = 1'b0; d_ptw_req_ready = 1'b0;
    d_ptw_resp_valid = 1'b0; d_ptw_resp_err = 1'b0;
    d_imem_vpn = '0; d_dmem_vpn = '0; d_ptw_resp_ppn = '0;
  endtask

  task automatic apply_drv();
    io_imem_req_valid      = d_imem_valid;
    io_imem_req_bits_vpn   = d_imem_vpn;
    io_dmem_req_valid      = d_dmem_valid;
    io_dmem_req_bits_vpn   = d_dmem_vpn;
    io_ptw_req_ready       = d_ptw_req_ready;
    io_ptw_resp_valid      = d_ptw_resp_valid;
    io_ptw_resp_bits_error = d_ptw_resp_err;
    io_ptw_resp_bits_ppn   = d_ptw_resp_ppn;
  endtask

  task automatic rand_drv();
    if (!d_imem_valid && $urandom_range(0, 2) == 0) begin
      d_imem_valid = 1'b1; d_imem_vpn = $urandom;
    end
    if (!d_dmem_valid && $urandom_range(0, 2) == 0) begin
      d_dmem_valid = 1'b1; d_dmem_vpn = $urandom;
    end
    d_ptw_req_ready  = ($urandom_range(0, 2) != 0);
    d_ptw_resp_valid = ($urandom_range(0, 3) == 0);
    d_ptw_resp_err   = 1'($urandom_range(0, 1));
    d_ptw_resp_ppn   = $urandom;
  endtask

  // One clock: drive at negedge, check 1ns later, then advance the model.
  task automatic run_cycle();
    logic e_ir, e_dr, e_pv;
    @(negedge clk);
    apply_drv();
    #1;
    e_ir = 1'b0;
    e_dr = 1'b0;
    if (!m_active) begin
      if (d_imem_valid && (!d_dmem_valid || m_rr == 1'b0)) e_ir = 1'b1;
      else if (d_dmem_valid)                               e_dr = 1'b1;
    end
    e_pv = m_active && !m_sent;
    check_val("imem_req_ready", 64'(io_imem_req_ready), 64'(e_ir));
    check_val("dmem_req_ready", 64'(io_dmem_req_ready), 64'(e_dr));
    check_val("ptw_req_valid", 64'(io_ptw_req_valid), 64'(e_pv));
    if (e_pv) check_val("ptw_req_vpn", 64'(io_ptw_req_bits_vpn), 64'(m_vpn));
    check_val("imem_resp_valid", 64'(io_imem_resp_valid), 64'(m_resp_now && m_owner == 1'b0));
    check_val("dmem_resp_valid", 64'(io_dmem_resp_valid), 64'(m_resp_now && m_owner == 1'b1));
    check_val("imem_resp_error", 64'(io_imem_resp_bits_error), 64'(m_err));
    check_val("dmem_resp_error", 64'(io_dmem_resp_bits_error), 64'(m_err));
    check_val("imem_resp_ppn", 64'(io_imem_resp_bits_ppn), 64'(m_ppn));
    check_val("dmem_resp_ppn", 64'(io_dmem_resp_bits_ppn), 64'(m_ppn));
    check_val("busy", 64'(io_busy), 64'(m_active));
    if (io_imem_req_valid && io_imem_req_ready) grant_log.push_back(0);
    if (io_dmem_req_valid && io_dmem_req_ready) grant_log.push_back(1);
    // advance the model by one clock
    if (m_active && m_resp_now) begin
      m_active   = 1'b0;
      m_resp_now = 1'b0;
      m_rr       = ~m_owner;
    end else if (m_active && !m_sent) begin
      if (d_ptw_req_ready) begin
        m_sent = 1'b1;
        m_wait = 0;
        n_accepts++;
        check_val("exp_q_depth", 64'(exp_q.size()), 64'(1));
        if (exp_q.size() > 0) check_val("ptw_accept_vpn", 64'(io_ptw_req_bits_vpn), 64'(exp_q.pop_front()));
      end
    end else if (m_active) begin
      if (d_ptw_resp_valid) begin
        m_err      = d_ptw_resp_err;
        m_ppn      = d_ptw_resp_ppn;
        m_resp_now = 1'b1;
      end
`ifdef PTW_ARB_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_err      = 1'b1;
          m_ppn      = '0;
          m_resp_now = 1'b1;
        end
      end
`endif
    end else if (e_ir) begin
      m_active = 1'b1; m_sent = 1'b0; m_owner = 1'b0; m_vpn = d_imem_vpn;
      exp_q.push_back(d_imem_vpn);
      d_imem_valid = 1'b0;
    end else if (e_dr) begin
      m_active = 1'b1; m_sent = 1'b0; m_owner = 1'b1; m_vpn = d_dmem_vpn;
      exp_q.push_back(d_dmem_vpn);
      d_dmem_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_drv();
    apply_drv();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Finish any walk in flight with a cooperative walker.
  task automatic drain(input string tag);
    d_imem_valid = 1'b0; d_dmem_valid = 1'b0;
    d_ptw_req_ready = 1'b1; d_ptw_resp_valid = 1'b1; d_ptw_resp_err = 1'b0;
    for (int i = 0; i < 20 && m_active; i++) begin
      d_ptw_resp_ppn = $urandom;
      run_cycle();
    end
    d_ptw_resp_valid = 1'b0;
    run_cycle();
    check_val(tag, 64'(io_busy), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [VPN_W-1:0] v;
  int waited;
  logic seen;

  initial begin
    clear_drv();
    model_reset();
    // Reset state, with both requesters raising valid while in reset.
    reset = 1'b1;
    apply_drv();
    io_imem_req_valid = 1'b1;
    io_dmem_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_imem_ready", 64'(io_imem_req_ready), 64'(0));
    check_val("rst_dmem_ready", 64'(io_dmem_req_ready), 64'(0));
    check_val("rst_ptw_req_valid", 64'(io_ptw_req_valid), 64'(0));
    check_val("rst_imem_resp_valid", 64'(io_imem_resp_valid), 64'(0));
    check_val("rst_dmem_resp_valid", 64'(io_dmem_resp_valid), 64'(0));
    check_val("rst_busy", 64'(io_busy), 64'(0));
    check_val("rst_ppn", 64'(io_imem_resp_bits_ppn), 64'(0));
    check_val("rst_err", 64'(io_dmem_resp_bits_error), 64'(0));
    @(negedge clk);
    apply_drv();
    reset = 1'b0;

    // Imem-only walk with minimum latency.
    d_imem_valid = 1'b1; d_imem_vpn = 32'h1234; d_ptw_req_ready = 1'b1;
    run_cycle();
    run_cycle();
    d_ptw_resp_valid = 1'b1; d_ptw_resp_ppn = 32'hABCD; d_ptw_resp_err = 1'b0;
    run_cycle();
    d_ptw_resp_valid = 1'b0;
    run_cycle();
    check_val("t031_imem_resp_valid", 64'(io_imem_resp_valid), 64'(1));
    check_val("t031_imem_ppn", 64'(io_imem_resp_bits_ppn), 64'(32'hABCD));
    check_val("t031_dmem_resp_valid", 64'(io_dmem_resp_valid), 64'(0));
    run_cycle();
    check_val("t031_resp_one_cycle", 64'(io_imem_resp_valid), 64'(0));

    // Spurious walker response while idle.
    d_ptw_resp_valid = 1'b1; d_ptw_resp_ppn = 32'h5555_0000; d_ptw_resp_err = 1'b1;
    run_cycle();
    d_ptw_resp_valid = 1'b0;
    run_cycle();
    check_val("t034_busy", 64'(io_busy), 64'(0));
    check_val("t034_no_resp", 64'({io_imem_resp_valid, io_dmem_resp_valid}), 64'(0));
    check_val("t034_ppn_kept", 64'(io_imem_resp_bits_ppn), 64'(32'hABCD));

    // Round robin from reset with both sides always requesting.
    do_reset();
    grant_log.delete();
    d_ptw_req_ready = 1'b1; d_ptw_resp_valid = 1'b1; d_ptw_resp_err = 1'b0;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) begin
      if (!d_imem_valid) begin d_imem_valid = 1'b1; d_imem_vpn = $urandom; end
      if (!d_dmem_valid) begin d_dmem_valid = 1'b1; d_dmem_vpn = $urandom; end
      d_ptw_resp_ppn = $urandom;
      run_cycle();
    end
    check_val("t032_grants", 64'(grant_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_val("t032_grant_order", 64'(grant_log[i]), 64'(i % 2));
    drain("t032_drain");

    // Walker stalls the request for 5 cycles.
    d_ptw_resp_valid = 1'b0;
    d_dmem_valid = 1'b1; d_dmem_vpn = $urandom; v = d_dmem_vpn; d_ptw_req_ready = 1'b0;
    run_cycle();
    n_accepts = 0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check_val("t033_valid_hold", 64'(io_ptw_req_valid), 64'(1));
      check_val("t033_vpn_hold", 64'(io_ptw_req_bits_vpn), 64'(v));
    end
    d_ptw_req_ready = 1'b1;
    repeat (3) run_cycle();
    check_val("t033_one_accept", 64'(n_accepts), 64'(1));
    drain("t033_drain");

    // Walker never answers.
    d_ptw_resp_valid = 1'b0;
    d_imem_valid = 1'b1; d_imem_vpn = $urandom; d_ptw_req_ready = 1'b1;
    run_cycle();
    run_cycle();
`ifdef PTW_ARB_TIMEOUT_EN
    waited = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      run_cycle();
      if (io_imem_resp_valid) seen = 1'b1;
      else waited++;
    end
    check_val("t036_timeout_seen", 64'(seen), 64'(1));
    check_val("t036_wait_cycles", 64'(waited), 64'(TMO));
    check_val("t036_error", 64'(io_imem_resp_bits_error), 64'(1));
    check_val("t036_ppn", 64'(io_imem_resp_bits_ppn), 64'(0));
    run_cycle();
`else
    repeat (20) run_cycle();
    check_val("t030_still_busy", 64'(io_busy), 64'(1));
    check_val("t030_no_resp", 64'(io_imem_resp_valid), 64'(0));
`endif
    drain("t030_drain");

    // Reset in the middle of a walk, then a late walker response.
    d_ptw_resp_valid = 1'b0;
    d_imem_valid = 1'b1; d_imem_vpn = $urandom; d_ptw_req_ready = 1'b1;
    run_cycle();
    run_cycle();
    run_cycle();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("t035_rst_busy", 64'(io_busy), 64'(0));
    check_val("t035_rst_ptw_valid", 64'(io_ptw_req_valid), 64'(0));
    check_val("t035_rst_ppn", 64'(io_imem_resp_bits_ppn), 64'(0));
    model_reset();
    clear_drv();
    @(negedge clk);
    reset = 1'b0;
    d_ptw_resp_valid = 1'b1; d_ptw_resp_ppn = 32'h7777; d_ptw_resp_err = 1'b0;
    repeat (3) run_cycle();
    check_val("t035_no_resp", 64'({io_imem_resp_valid, io_dmem_resp_valid}), 64'(0));
    check_val("t035_busy", 64'(io_busy), 64'(0));
    d_ptw_resp_valid = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_drv();
      run_cycle();
    end
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
